// File: rtl/cmos_pixel_capture.sv
// cmos_pixel_capture: DVP byte stream to RGB565 pixel FIFO writer with frame gating and error reporting
module cmos_pixel_capture #(
    parameter int WAIT_FRAMES = 10,
    parameter int H_PIXEL     = 800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        fifo_full,
    output logic        fifo_clr,
    output logic        pix_wr_en,
    output logic [15:0] pix_wr_data,
    output logic        frame_valid,
    output logic        line_err,
    output logic [15:0] ovf_cnt
);
    localparam logic [1:0]  S_WAIT = 2'd0;
    localparam logic [1:0]  S_ARM  = 2'd1;
    localparam logic [1:0]  S_CAP  = 2'd2;
    localparam logic [11:0] LINE_BYTES = 12'(2 * H_PIXEL);
    logic        vs_d1, vs_d2, hs_d1, hs_d2;
    logic [7:0]  data_d1, hi;
    logic [1:0]  state;
    logic [7:0]  fcnt;
    logic        phase, trk;
    logic [11:0] bcnt;
    logic        vs_rise, hs_fall, cap, pix;
    assign vs_rise = vs_d1 & ~vs_d2;
    assign hs_fall = ~hs_d1 & hs_d2;
    assign cap     = (state == S_CAP) && !vs_rise;
    assign pix     = cap && hs_d1 && phase;
    // register the camera bus once and keep a second tap for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_d1   <= 1'b0;
            vs_d2   <= 1'b0;
            hs_d1   <= 1'b0;
            hs_d2   <= 1'b0;
            data_d1 <= 8'd0;
        end else begin
            vs_d1   <= cam_vsync;
            vs_d2   <= vs_d1;
            hs_d1   <= cam_href;
            hs_d2   <= hs_d1;
            data_d1 <= cam_data;
        end
    end
    // frame gating: settle, arm, then capture whole frames decided at each frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_WAIT;
            fcnt        <= 8'd0;
            frame_valid <= 1'b0;
            fifo_clr    <= 1'b0;
        end else begin
            fifo_clr <= 1'b0;
            if (state == S_WAIT) begin
                if (WAIT_FRAMES == 0) begin
                    state       <= S_ARM;
                    frame_valid <= 1'b1;
                end else if (vs_rise) begin
                    fcnt <= fcnt + 8'd1;
                    if (fcnt + 8'd1 == 8'(WAIT_FRAMES)) begin
                        state       <= S_ARM;
                        frame_valid <= 1'b1;
                    end
                end
            end else if (vs_rise) begin
                fifo_clr <= enable;
                state    <= enable ? S_CAP : S_ARM;
            end
        end
    end
    // pair bytes into pixels and either write them or count them as dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= 1'b0;
            hi          <= 8'd0;
            pix_wr_en   <= 1'b0;
            pix_wr_data <= 16'd0;
            ovf_cnt     <= 16'd0;
        end else begin
            pix_wr_en <= pix && !fifo_full;
            if (pix && !fifo_full)
                pix_wr_data <= {hi, data_d1};
            if (pix && fifo_full && ovf_cnt != 16'hFFFF)
                ovf_cnt <= ovf_cnt + 16'd1;
            if (cap && hs_d1 && !phase)
                hi <= data_d1;
            phase <= cap && hs_d1 && !phase;
        end
    end
    // count bytes per line; trk guards against judging a line that began before capture
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt     <= 12'd0;
            trk      <= 1'b0;
            line_err <= 1'b0;
        end else if (vs_rise) begin
            bcnt <= 12'd0;
            trk  <= ~hs_d1;
        end else if (state != S_CAP) begin
            bcnt <= 12'd0;
            trk  <= 1'b0;
        end else begin
            if (hs_fall) begin
                bcnt <= 12'd0;
                if (trk && bcnt != LINE_BYTES)
                    line_err <= 1'b1;
            end else if (hs_d1) begin
                bcnt <= bcnt + 12'd1;
            end
            trk <= trk | ~hs_d1;
        end
    end
endmodule

// File: tb/tb_cmos_pixel_capture.sv
// tb_cmos_pixel_capture: scenario and randomized checks against a frame-level reference model
module tb_cmos_pixel_capture;
    localparam int WF = 2;
    localparam int HP = 4;
    logic        clk = 1'b0;
    logic        rst, enable, cam_vsync, cam_href, fifo_full;
    logic [7:0]  cam_data;
    logic        fifo_clr, pix_wr_en, frame_valid, line_err;
    logic [15:0] pix_wr_data, ovf_cnt;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] e_pix;
    int          clr_cnt = 0;
    int          clr_base = 0;
    logic        prev_en = 1'b0;
    int          m_frames, m_ovf, m_clr;
    bit          m_valid, m_cap, m_err;

    cmos_pixel_capture #(.WAIT_FRAMES(WF), .H_PIXEL(HP)) dut (
        .clk(clk), .rst(rst), .enable(enable), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_data(cam_data), .fifo_full(fifo_full),
        .fifo_clr(fifo_clr), .pix_wr_en(pix_wr_en), .pix_wr_data(pix_wr_data),
        .frame_valid(frame_valid), .line_err(line_err), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    // scoreboard: every write must match the next pixel the model expects
    always @(negedge clk) begin
        if (!rst) begin
            if (pix_wr_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write got=%h expected=none", pix_wr_data);
                end else begin
                    e_pix = exp_q.pop_front();
                    if (pix_wr_data !== e_pix) begin
                        failures++;
                        $display("FAIL write_data got=%h expected=%h", pix_wr_data, e_pix);
                    end
                end
                if (prev_en) begin
                    failures++;
                    $display("FAIL back_to_back_write got=consecutive expected=gap");
                end
            end
            if (fifo_clr) clr_cnt++;
            prev_en = pix_wr_en;
        end else begin
            prev_en = 1'b0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cam_vsync = 1'b0;
        cam_href = 1'b0;
        cam_data = 8'd0;
        fifo_full = 1'b0;
        tick(2);
        rst = 1'b0;
        m_frames = 0; m_valid = (WF == 0); m_cap = 0; m_err = 0; m_ovf = 0; m_clr = 0;
        clr_base = clr_cnt;
    endtask

    task automatic vsync();
        if (!m_valid) begin
            m_frames++;
            if (m_frames == WF) m_valid = 1;
        end else if (enable) begin
            m_cap = 1;
            m_clr++;
        end else begin
            m_cap = 0;
        end
        cam_href = 1'b0;
        cam_vsync = 1'b1;
        tick(2);
        cam_vsync = 1'b0;
        tick(3);
    endtask

    task automatic send_line(input int n, input bit [3:0] mask, input bit fixed, input logic [63:0] pat);
        logic [7:0] b[16];
        for (int i = 0; i < 16; i++) b[i] = (fixed && i < 8) ? pat[63 - 8*i -: 8] : 8'($urandom);
        if (m_cap) begin
            for (int p = 0; p < n / 2; p++) begin
                if (mask[p]) m_ovf++;
                else exp_q.push_back({b[2*p], b[2*p+1]});
            end
            if (n != 2 * HP) m_err = 1;
        end
        for (int j = 0; j <= n; j++) begin
            cam_href = (j < n);
            cam_data = (j < n) ? b[j] : 8'd0;
            fifo_full = (j >= 2 && j % 2 == 0) ? mask[j/2 - 1] : 1'b0;
            tick();
        end
        cam_href = 1'b0;
        fifo_full = 1'b0;
        tick(4);
    endtask

    task automatic test_reset();
        enable = 1'b1;
        do_reset();
        checks++;
        if ({frame_valid, fifo_clr, pix_wr_en, pix_wr_data, line_err, ovf_cnt} !== 36'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h expected=0",
                     {frame_valid, fifo_clr, pix_wr_en, pix_wr_data, line_err, ovf_cnt});
        end
    endtask

    task automatic test_basic();
        vsync();
        checks++;
        if (frame_valid !== m_valid) begin failures++; $display("FAIL valid_after_vs1 got=%b expected=%b", frame_valid, m_valid); end
        send_line(8, 4'b0, 0, 64'd0);
        vsync();
        checks++;
        if (frame_valid !== 1'b1) begin failures++; $display("FAIL valid_after_vs2 got=%b expected=1", frame_valid); end
        vsync();
        send_line(8, 4'b0, 1, 64'hF800_07E0_001F_FFFF);
        checks++;
        if (clr_cnt - clr_base !== m_clr) begin failures++; $display("FAIL basic_clr got=%0d expected=%0d", clr_cnt - clr_base, m_clr); end
        checks++;
        if (exp_q.size() !== 0) begin failures++; $display("FAIL basic_missing_writes got=%0d expected=0", exp_q.size()); end
        checks++;
        if (line_err !== 1'b0) begin failures++; $display("FAIL basic_line_err got=%b expected=0", line_err); end
    endtask

    task automatic test_short_line();
        send_line(7, 4'b0, 0, 64'd0);
        checks++;
        if (line_err !== 1'b1) begin failures++; $display("FAIL short_line_err got=%b expected=1", line_err); end
        send_line(8, 4'b0, 0, 64'd0);
        checks++;
        if (line_err !== 1'b1 || exp_q.size() !== 0) begin
            failures++; $display("FAIL short_sticky got=%b/%0d expected=1/0", line_err, exp_q.size());
        end
    endtask

    task automatic test_overflow();
        send_line(8, 4'b0110, 0, 64'd0);
        checks++;
        if (ovf_cnt !== 16'(m_ovf) || m_ovf != 2) begin failures++; $display("FAIL overflow_count got=%0d expected=2", ovf_cnt); end
        checks++;
        if (exp_q.size() !== 0) begin failures++; $display("FAIL overflow_writes got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_enable_arm();
        enable = 1'b0;
        vsync();
        vsync();
        send_line(8, 4'b0, 0, 64'd0);
        enable = 1'b1;
        send_line(8, 4'b0, 0, 64'd0);
        checks++;
        if (clr_cnt - clr_base !== m_clr) begin failures++; $display("FAIL arm_no_clr got=%0d expected=%0d", clr_cnt - clr_base, m_clr); end
        vsync();
        send_line(8, 4'b0, 0, 64'd0);
        checks++;
        if (clr_cnt - clr_base !== m_clr || exp_q.size() !== 0) begin
            failures++; $display("FAIL arm_resume got=%0d/%0d expected=%0d/0", clr_cnt - clr_base, exp_q.size(), m_clr);
        end
    endtask

    task automatic test_drop_enable();
        send_line(8, 4'b0, 0, 64'd0);
        enable = 1'b0;
        send_line(8, 4'b0, 0, 64'd0);
        send_line(8, 4'b0, 0, 64'd0);
        vsync();
        send_line(8, 4'b0, 0, 64'd0);
        checks++;
        if (clr_cnt - clr_base !== m_clr || exp_q.size() !== 0) begin
            failures++; $display("FAIL drop_enable got=%0d/%0d expected=%0d/0", clr_cnt - clr_base, exp_q.size(), m_clr);
        end
        enable = 1'b1;
    endtask

    task automatic test_rst_mid_line();
        vsync();
        cam_href = 1'b1;
        cam_data = 8'hA5;
        tick();
        rst = 1'b1;
        cam_data = 8'h5A;
        tick();
        checks++;
        if ({frame_valid, fifo_clr, pix_wr_en, pix_wr_data, line_err, ovf_cnt} !== 36'd0) begin
            failures++;
            $display("FAIL midline_reset got=%h expected=0",
                     {frame_valid, fifo_clr, pix_wr_en, pix_wr_data, line_err, ovf_cnt});
        end
        do_reset();
        vsync();
        send_line(8, 4'b0, 0, 64'd0);
        vsync();
        send_line(8, 4'b0, 0, 64'd0);
        checks++;
        if (clr_cnt - clr_base !== 0 || frame_valid !== 1'b1) begin
            failures++; $display("FAIL rewait got=%0d/%b expected=0/1", clr_cnt - clr_base, frame_valid);
        end
        vsync();
        send_line(8, 4'b0, 0, 64'd0);
        checks++;
        if (clr_cnt - clr_base !== 1 || exp_q.size() !== 0) begin
            failures++; $display("FAIL rewait_capture got=%0d/%0d expected=1/0", clr_cnt - clr_base, exp_q.size());
        end
    endtask

    task automatic test_random();
        int lens[6] = '{6, 7, 8, 8, 8, 9};
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                enable = ($urandom_range(0, 4) != 0);
                vsync();
            end else begin
                if ($urandom_range(0, 7) == 0) enable = ~enable;
                send_line(lens[$urandom_range(0, 5)], 4'($urandom), 0, 64'd0);
            end
        end
        checks++;
        if (exp_q.size() !== 0) begin failures++; $display("FAIL random_writes got=%0d expected=0", exp_q.size()); end
        checks++;
        if (clr_cnt - clr_base !== m_clr) begin failures++; $display("FAIL random_clr got=%0d expected=%0d", clr_cnt - clr_base, m_clr); end
        checks++;
        if (ovf_cnt !== 16'(m_ovf)) begin failures++; $display("FAIL random_ovf got=%0d expected=%0d", ovf_cnt, m_ovf); end
        checks++;
        if (line_err !== m_err) begin failures++; $display("FAIL random_line_err got=%b expected=%b", line_err, m_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_line();
        test_overflow();
        test_enable_arm();
        test_drop_enable();
        test_rst_mid_line();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cmos_pixel_capture.md
# cmos_pixel_capture

Camera-side capture stage that feeds the MCU LCD display path. It samples the OV5640 DVP bus (8-bit data, HREF, VSYNC) and packs byte pairs into RGB565 pixels. It writes them into the pixel FIFO whose read side (`pixel_data`, `rdusedw`) is consumed by the LCD driver. It holds off for a configurable number of frames after reset, starts only on a frame boundary, clears the FIFO at each frame start, and reports line-length errors and FIFO overflow.

## Interface
Parameters:
- `WAIT_FRAMES`, default 10: frames ignored after reset while camera registers settle; 0 means arm immediately.
- `H_PIXEL`, default 800: expected pixels per line; a line must contain exactly 2*H_PIXEL bytes.

Ports:
- `clk`  in  1  camera pixel clock (cam_pclk); the only clock
- `rst`  in  1  synchronous reset, active-high
- `enable`  in  1  capture permission (driven by `lcd_init_done`); sampled only at frame start
- `cam_vsync`  in  1  camera VSYNC, active-high
- `cam_href`  in  1  camera HREF, high during valid line bytes
- `cam_data`  in  8  camera data; high byte of each pixel first
- `fifo_full`  in  1  pixel FIFO full flag
- `fifo_clr`  out  1  one-cycle FIFO clear pulse at each captured frame start
- `pix_wr_en`  out  1  FIFO write strobe, one cycle per pixel
- `pix_wr_data`  out  16  RGB565 pixel {high byte, low byte}
- `frame_valid`  out  1  high once WAIT_FRAMES frames have elapsed
- `line_err`  out  1  sticky flag: a captured line had the wrong byte count
- `ovf_cnt`  out  16  saturating count of pixels dropped because of `fifo_full`

## Operation
- Input stage: `cam_vsync`, `cam_href` and `cam_data` are each registered once (`_d1`). `vs_d2` and `hs_d2` are one further delay. The frame-start event is vs_rise = vs_d1 & ~vs_d2. The line-end event is hs_fall = ~hs_d1 & hs_d2.
- State machine:
  - S_WAIT: an 8-bit frame counter increments on each vs_rise. When the counter reaches WAIT_FRAMES, go to S_ARM and set `frame_valid` (it stays high until `rst`). With WAIT_FRAMES=0, go to S_ARM on the first cycle after reset.
  - S_ARM: on vs_rise with `enable`=1, pulse `fifo_clr` and go to S_CAP. On vs_rise with `enable`=0, stay in S_ARM. No writes occur in S_ARM.
  - S_CAP: on vs_rise with `enable`=1, pulse `fifo_clr` and stay. On vs_rise with `enable`=0, go to S_ARM. A mid-frame drop of `enable` is ignored, so the current frame always completes.
- Packing, in S_CAP only, while hs_d1=1:
  - A byte-phase bit toggles on each byte. Phase 0 latches the high byte.
  - Phase 1 forms {hi, lo}. If `fifo_full`=0, assert `pix_wr_en` with that data. If `fifo_full`=1, suppress the write and increment `ovf_cnt` (saturating at 0xFFFF).
  - While hs_d1=0, byte phase is forced to 0. A trailing odd byte is discarded.
- Line check, in S_CAP: a 12-bit byte counter counts hs_d1=1 cycles. On hs_fall, if count != 2*H_PIXEL, set `line_err`. The counter is cleared at each hs_fall. The check is not performed for a line already in progress when S_CAP is entered.
- `line_err` and `ovf_cnt` are cleared only by `rst`.

## Timing
- On `rst`=1 at an edge, all outputs become 0 at that edge. State goes to S_WAIT, the frame counter to 0, byte phase to 0, and the delay registers to 0.
- `fifo_clr`: if `cam_vsync` is first sampled high at edge N, `fifo_clr` is high from edge N+1 to N+2 (exactly one cycle).
- Pixel write: if the low byte is sampled at edge N, `pix_wr_en` and `pix_wr_data` are valid from N+1 to N+2. `pix_wr_data` holds its last value when no write occurs.
- Maximum write rate is one write every 2 cycles. `pix_wr_en` is never high for two consecutive cycles.
- `fifo_full` is sampled in the same cycle the write would be issued, i.e. the cycle at edge N+1.
- vs_rise coinciding with hs_d1=1 (a malformed stream): the frame-start action takes priority. Byte phase and the byte counter are reset, and no `line_err` is raised for the truncated line.
- `frame_valid` rises at the edge that registers the WAIT_FRAMES-th vs_rise.

## Test plan
- WAIT_FRAMES=2, H_PIXEL=4, `enable`=1; three VSYNC pulses, then one line of 8 bytes F8 00 07 E0 00 1F FF FF -> no writes before the 3rd VSYNC. `frame_valid`=1 after the 2nd VSYNC, one `fifo_clr` pulse at the 3rd, then 4 writes: 0xF800, 0x07E0, 0x001F, 0xFFFF. `line_err`=0.
- Captured line of 7 bytes -> 3 writes, the 7th byte is dropped, `line_err`=1 and it stays 1 across later good lines.
- `fifo_full`=1 during the 2nd and 3rd pixel of a 4-pixel line -> 2 writes (pixels 1 and 4), `ovf_cnt`=2.
- `enable`=0 at a VSYNC while in S_ARM -> no `fifo_clr` and no writes. Raise `enable` mid-frame -> still no writes until the next VSYNC, which produces `fifo_clr`.
- `enable` dropped mid-frame in S_CAP -> the remaining lines of the frame are written. At the next VSYNC there is no `fifo_clr` and writes stop.
- `rst` asserted mid-line in S_CAP -> all outputs 0 at that edge. After release, WAIT_FRAMES VSYNCs must elapse again before any write.
